// File: rtl/vend_pkg.sv
// vend_pkg -- shared definitions for the multi-item vending controller.
//   vend_state_e : FSM state encoding, also driven out on the 3-bit state port.
//   COIN_*       : coin codes on the 2-bit coin input.
//   coin_units() : coin code -> credit units (1 unit = one quarter).
// Optional feature macro: VEND_CANCEL_EN adds the REFUND state.
package vend_pkg;

  // Encodings are fixed so that builds with and without cancel agree
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3
`ifdef VEND_CANCEL_EN
    , ST_REFUND = 3'd4
`endif
  } vend_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_Q1   = 2'b01;
  localparam logic [1:0] COIN_Q2   = 2'b10;
  localparam logic [1:0] COIN_Q4   = 2'b11;

  function automatic logic [2:0] coin_units(input logic [1:0] c);
    case (c)
      COIN_Q1: return 3'd1;
      COIN_Q2: return 3'd2;
      COIN_Q4: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_ctr.sv
// vend_change_ctr -- one payout step for CHANGE / REFUND.
// Given the remaining credit, says whether a quarter goes out this step,
// what credit is left afterwards, and whether payout is already complete.
//   credit_i : remaining credit in units
//   pulse_o  : a quarter is returned on this step
//   credit_o : credit after this step
//   done_o   : nothing left to return
module vend_change_ctr #(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic                pulse_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                done_o
);

  assign done_o   = (credit_i == '0);
  assign pulse_o  = !done_o;
  assign credit_o = done_o ? credit_i : credit_i - CREDIT_W'(1);

endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi -- coin-operated vending controller with N_ITEMS priced items.
// Accepts quarters (1/2/4 units), vends on a valid selection with enough
// credit, then returns leftover credit one quarter per cycle.
// Optional feature macro: VEND_CANCEL_EN adds a cancel input that refunds
// credit from the CREDIT state.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   coin_valid, coin            : coin presented (00 means no coin)
//   sel_valid, sel              : item selection
//   vend_valid, vend_item,
//   vend_ready                  : dispense handshake
//   change_pulse                : one returned quarter per high cycle
//   coin_reject, sel_denied     : single-cycle pulses
//   credit, state               : current credit (units) and FSM state
//   cancel (VEND_CANCEL_EN)     : refund request
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 16,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICE =
    {CREDIT_W'(8), CREDIT_W'(6), CREDIT_W'(5), CREDIT_W'(4)}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coin_valid,
  input  logic [1:0]                 coin,
  input  logic                       sel_valid,
  input  logic [$clog2(N_ITEMS)-1:0] sel,
  input  logic                       vend_ready,
`ifdef VEND_CANCEL_EN
  input  logic                       cancel,
`endif
  output logic                       vend_valid,
  output logic [$clog2(N_ITEMS)-1:0] vend_item,
  output logic                       change_pulse,
  output logic                       coin_reject,
  output logic                       sel_denied,
  output logic [CREDIT_W-1:0]        credit,
  output logic [2:0]                 state
);

  localparam int SEL_W = $clog2(N_ITEMS);

  vend_state_e         state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                vend_valid_q, change_pulse_q, coin_reject_q, sel_denied_q;
  logic [SEL_W-1:0]    vend_item_q;

  // Coin evaluation; sum carries 3 extra bits so the ceiling test never wraps
  logic [2:0]          units;
  logic                coin_pres;
  logic [CREDIT_W+2:0] credit_sum;
  logic                coin_fits;

  assign units      = coin_units(coin);
  assign coin_pres  = coin_valid && (units != 3'd0);
  assign credit_sum = {3'b000, credit_q} + {{CREDIT_W{1'b0}}, units};
  assign coin_fits  = (credit_sum <= (CREDIT_W+3)'(MAX_CREDIT));

  // Selection evaluation; out-of-range selections see price 0 but are
  // filtered by sel_legal
  logic [CREDIT_W-1:0] price;
  logic                sel_legal, can_buy;

  always_comb begin
    price = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (sel == SEL_W'(i)) price = ITEM_PRICE[i*CREDIT_W +: CREDIT_W];
  end

  assign sel_legal = ({1'b0, sel} < (SEL_W+1)'(N_ITEMS));
  assign can_buy   = sel_legal && (credit_q >= price);

  // Payout step always looks at the live credit, so the same step serves
  // the first quarter on leaving VEND / CREDIT and each following one
  logic                pay_pulse_d, pay_done_d;
  logic [CREDIT_W-1:0] pay_credit_d;

  vend_change_ctr #(.CREDIT_W(CREDIT_W)) u_change (
    .credit_i (credit_q),
    .pulse_o  (pay_pulse_d),
    .credit_o (pay_credit_d),
    .done_o   (pay_done_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_denied_q   <= 1'b0;
    end else begin
      coin_reject_q  <= 1'b0;
      sel_denied_q   <= 1'b0;
      change_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Credit is always 0 here, so any selection is unaffordable
          if (sel_valid) sel_denied_q <= 1'b1;
          if (coin_pres) begin
            if (coin_fits) begin
              credit_q <= credit_sum[CREDIT_W-1:0];
              state_q  <= ST_CREDIT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end
        ST_CREDIT: begin
`ifdef VEND_CANCEL_EN
          if (cancel) begin
            coin_reject_q  <= coin_pres;
            change_pulse_q <= pay_pulse_d;
            credit_q       <= pay_credit_d;
            state_q        <= ST_REFUND;
          end else
`endif
          if (sel_valid) begin
            // Selection wins; a coppresented coin is bounced either way
            coin_reject_q <= coin_pres;
            if (can_buy) begin
              credit_q     <= credit_q - price;
              vend_item_q  <= sel;
              vend_valid_q <= 1'b1;
              state_q      <= ST_VEND;
            end else begin
              sel_denied_q <= 1'b1;
            end
          end else if (coin_pres) begin
            if (coin_fits) credit_q <= credit_sum[CREDIT_W-1:0];
            else           coin_reject_q <= 1'b1;
          end
        end
        ST_VEND: begin
          coin_reject_q <= coin_pres;
          if (vend_ready) begin
            vend_valid_q   <= 1'b0;
            change_pulse_q <= pay_pulse_d;
            credit_q       <= pay_credit_d;
            state_q        <= pay_done_d ? ST_IDLE : ST_CHANGE;
          end
        end
        ST_CHANGE
`ifdef VEND_CANCEL_EN
        , ST_REFUND
`endif
        : begin
          coin_reject_q  <= coin_pres;
          change_pulse_q <= pay_pulse_d;
          credit_q       <= pay_credit_d;
          if (pay_done_d) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign credit       = credit_q;
  assign vend_valid   = vend_valid_q;
  assign vend_item    = vend_item_q;
  assign change_pulse = change_pulse_q;
  assign coin_reject  = coin_reject_q;
  assign sel_denied   = sel_denied_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi -- self-checking bench for vend_ctrl_multi (default
// parameters: prices 4/5/6/8, ceiling 16). Directed vector table, a few
// multi-cycle sequences, then randomized stimulus against a reference model.
// Optional feature macro: VEND_CANCEL_EN enables the cancel/refund checks.
module tb_vend_ctrl_multi;
  import vend_pkg::*;

  localparam int I  = int'(ST_IDLE);
  localparam int C  = int'(ST_CREDIT);
  localparam int V  = int'(ST_VEND);
  localparam int CH = int'(ST_CHANGE);
  localparam int MAXC = 16;

  logic clk = 1'b0;
  logic rst, coin_valid, sel_valid, vend_ready;
  logic [1:0] coin, sel;
  logic vend_valid, change_pulse, coin_reject, sel_denied;
  logic [1:0] vend_item;
  logic [5:0] credit;
  logic [2:0] state;
`ifdef VEND_CANCEL_EN
  logic cancel = 1'b0;
`endif

  vend_ctrl_multi dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel(sel), .vend_ready(vend_ready),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .vend_valid(vend_valid), .vend_item(vend_item), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .sel_denied(sel_denied), .credit(credit), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic r, cv; logic [1:0] cn; logic sv; logic [1:0] s; logic rdy;
    logic [14:0] exp;
  } vec_t;

  function automatic logic [14:0] pk(int st, int cr, int vv, int it, int pl, int rj, int dn);
    return {3'(st), 6'(cr), 1'(vv), 2'(it), 1'(pl), 1'(rj), 1'(dn)};
  endfunction

  function automatic vec_t v(logic r, logic cv, logic [1:0] cn, logic sv, logic [1:0] s,
                             logic rdy, int st, int cr, int vv, int it, int pl, int rj, int dn);
    vec_t x;
    x.r = r; x.cv = cv; x.cn = cn; x.sv = sv; x.s = s; x.rdy = rdy;
    x.exp = pk(st, cr, vv, it, pl, rj, dn);
    return x;
  endfunction

  function automatic logic [14:0] dut_vec();
    return {state, credit, vend_valid, vend_item, change_pulse, coin_reject, sel_denied};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, return #1 after the capturing edge
  task automatic cyc(input logic r, input logic cv, input logic [1:0] cn,
                     input logic sv, input logic [1:0] s, input logic rdy);
    rst = r; coin_valid = cv; coin = cn; sel_valid = sv; sel = s; vend_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int price [4] = '{4, 5, 6, 8};
  int m_st, m_cr, m_vv, m_it, m_pl, m_rj, m_dn;

  task automatic model_step(input bit r, input bit cv, input int cn, input bit sv,
                            input int s, input bit rdy, input bit cc);
    int u;
    bit cin;
    u   = (cn == 1) ? 1 : (cn == 2) ? 2 : (cn == 3) ? 4 : 0;
    cin = cv && (u > 0);
    m_pl = 0; m_rj = 0; m_dn = 0;
    if (r) begin
      m_st = I; m_cr = 0; m_vv = 0; m_it = 0;
    end else if (m_st == I) begin
      if (sv) m_dn = 1;
      if (cin) begin
        if (m_cr + u <= MAXC) begin m_cr += u; m_st = C; end
        else m_rj = 1;
      end
    end else if (m_st == C) begin
      if (cc) begin
        m_rj = int'(cin);
`ifdef VEND_CANCEL_EN
        m_st = int'(ST_REFUND);
`endif
        if (m_cr > 0) begin m_pl = 1; m_cr--; end
      end else if (sv) begin
        m_rj = int'(cin);
        if (s < 4 && m_cr >= price[s]) begin
          m_cr -= price[s]; m_it = s; m_vv = 1; m_st = V;
        end else m_dn = 1;
      end else if (cin) begin
        if (m_cr + u <= MAXC) m_cr += u;
        else m_rj = 1;
      end
    end else if (m_st == V) begin
      m_rj = int'(cin);
      if (rdy) begin
        m_vv = 0;
        if (m_cr > 0) begin m_pl = 1; m_cr--; m_st = CH; end
        else m_st = I;
      end
    end else begin
      // CHANGE or REFUND: one quarter back per cycle until empty
      m_rj = int'(cin);
      if (m_cr > 0) begin m_pl = 1; m_cr--; end
      else m_st = I;
    end
  endtask

  vec_t tbl[$];

  initial begin
    int pulses;
    bit r, cv, sv, rdy, cc;
    int cn, s;

    rst = 1'b1; coin_valid = 0; coin = 0; sel_valid = 0; sel = 0; vend_ready = 0;

    // r cv cn sv s rdy | st cr vv it pl rj dn
    tbl.push_back(v(1,0,0,0,0,0, I, 0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0, C, 1,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0, C, 2,0,0,0,0,0));
    tbl.push_back(v(0,1,2,0,0,0, C, 4,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0, V, 0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1, I, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, I, 0,0,0,0,0,0));
    tbl.push_back(v(0,1,3,0,0,0, C, 4,0,0,0,0,0));
    tbl.push_back(v(0,1,3,0,0,0, C, 8,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,1,0, V, 3,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1, CH,2,0,1,1,0,0));
    tbl.push_back(v(0,1,2,0,0,0, CH,1,0,1,1,1,0));
    tbl.push_back(v(0,0,0,1,0,0, CH,0,0,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0, I, 0,0,1,0,0,0));
    tbl.push_back(v(0,1,3,0,0,0, C, 4,0,1,0,0,0));
    tbl.push_back(v(0,1,3,0,0,0, C, 8,0,1,0,0,0));
    tbl.push_back(v(0,1,3,0,0,0, C,12,0,1,0,0,0));
    tbl.push_back(v(0,1,2,0,0,0, C,14,0,1,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0, C,15,0,1,0,0,0));
    tbl.push_back(v(0,1,2,0,0,0, C,15,0,1,0,1,0));
    tbl.push_back(v(0,1,1,0,0,0, C,16,0,1,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0, C,16,0,1,0,1,0));
    tbl.push_back(v(1,0,0,0,0,0, I, 0,0,0,0,0,0));
    tbl.push_back(v(0,1,3,0,0,0, C, 4,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,3,0, C, 4,0,0,0,0,1));
    tbl.push_back(v(0,1,1,1,0,0, V, 0,1,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,1, I, 0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, I, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0, I, 0,0,0,0,0,1));

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].cv, tbl[k].cn, tbl[k].sv, tbl[k].s, tbl[k].rdy);
      check($sformatf("table[%0d]", k), 32'(dut_vec()), 32'(tbl[k].exp));
    end

    // Long vend_ready stall, then reset in the middle of change payout
    cyc(0,1,3,0,0,0);
    cyc(0,1,3,0,0,0);
    cyc(0,0,0,1,2,0);
    check("vend_start", 32'(dut_vec()), 32'(pk(V,2,1,2,0,0,0)));
    for (int k = 0; k < 10; k++) begin
      cyc(0,0,0,0,0,0);
      check($sformatf("vend_hold[%0d]", k), 32'(dut_vec()), 32'(pk(V,2,1,2,0,0,0)));
    end
    cyc(0,0,0,0,0,1);
    check("change_first", 32'(dut_vec()), 32'(pk(CH,1,0,2,1,0,0)));
    cyc(1,0,0,0,0,0);
    check("rst_mid_change", 32'(dut_vec()), 32'(pk(I,0,0,0,0,0,0)));
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(0,0,0,0,0,0);
      pulses += int'(change_pulse);
    end
    check("pulses_after_rst", 32'(pulses), 32'd0);
    check("idle_after_rst", 32'(dut_vec()), 32'(pk(I,0,0,0,0,0,0)));

`ifdef VEND_CANCEL_EN
    cyc(0,1,3,0,0,0);
    cyc(0,1,2,0,0,0);
    check("pre_cancel", 32'(dut_vec()), 32'(pk(C,6,0,0,0,0,0)));
    cancel = 1'b1;
    cyc(0,1,1,1,0,0);
    cancel = 1'b0;
    check("cancel_enter", 32'(dut_vec()), 32'(pk(int'(ST_REFUND),5,0,0,1,1,0)));
    pulses = 1;
    for (int k = 0; k < 20; k++) begin
      cyc(0,0,0,0,0,0);
      pulses += int'(change_pulse);
      if (state == 3'(I)) break;
    end
    check("refund_pulses", 32'(pulses), 32'd6);
    check("refund_done", 32'(dut_vec()), 32'(pk(I,0,0,0,0,0,0)));
    cancel = 1'b1;
    cyc(0,0,0,0,0,0);
    cancel = 1'b0;
    check("cancel_idle_ignored", 32'(dut_vec()), 32'(pk(I,0,0,0,0,0,0)));
`endif

    // Randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      r   = (k == 0) || ($urandom_range(63) == 0);
      cv  = ($urandom_range(2) == 0);
      cn  = int'($urandom_range(3));
      sv  = ($urandom_range(4) == 0);
      s   = int'($urandom_range(3));
      rdy = ($urandom_range(2) == 0);
      cc  = 1'b0;
`ifdef VEND_CANCEL_EN
      cc = ($urandom_range(7) == 0);
      cancel = cc;
`endif
      model_step(r, cv, cn, sv, s, rdy, cc);
      cyc(r, cv, 2'(cn), sv, 2'(s), rdy);
      check($sformatf("random[%0d]", k), 32'(dut_vec()),
            32'(pk(m_st, m_cr, m_vv, m_it, m_pl, m_rj, m_dn)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
